// File: rtl/line_moment_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// line_moment_ctrl_pkg
//
// Shared definitions for the per-line skin-moment scheduler:
//   - result field widths (sum of x, skin pixel count, x counter)
//   - scheduler FSM state encoding
//   - result record {sum, cnt, line} at the default line-index width
//   - saturating increment helper used by the x counter
// -----------------------------------------------------------------------------
package line_moment_ctrl_pkg;

  localparam int LINE_MOMENT_SUM_W  = 19;
  localparam int LINE_MOMENT_CNT_W  = 10;
  localparam int LINE_MOMENT_X_W    = 10;
  localparam int LINE_MOMENT_LINE_W = 9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    COMMIT = 2'd2
  } line_state_e;

  // Result record at the default line-index width. The block itself re-declares
  // the same layout at its LINE_W parameter so the index is never truncated.
  typedef struct packed {
    logic [LINE_MOMENT_SUM_W-1:0]  sum;
    logic [LINE_MOMENT_CNT_W-1:0]  cnt;
    logic [LINE_MOMENT_LINE_W-1:0] line;
  } line_moment_res_t;

  // Increment that sticks at lim instead of wrapping.
  function automatic logic [LINE_MOMENT_X_W-1:0] sat_inc(
    input logic [LINE_MOMENT_X_W-1:0] v,
    input logic [LINE_MOMENT_X_W-1:0] lim
  );
    return (v < lim) ? v + LINE_MOMENT_X_W'(1) : v;
  endfunction

endpackage

// File: rtl/line_moment_ctrl_summator.sv
// -----------------------------------------------------------------------------
// summator
//
// Clock-enabled accumulator: Y <= Y + A when ce, cleared by rst.
// Y is the register itself, so it reflects every addend up to and including
// the previous edge (zero combinational latency).
//
// Ports:
//   clk  in   clock, rising edge
//   rst  in   synchronous clear (active high), has priority over ce
//   ce   in   add enable
//   A    in   A_W-bit unsigned addend
//   Y    out  Y_W-bit running sum
// -----------------------------------------------------------------------------
module summator
  import line_moment_ctrl_pkg::*;
#(
  parameter int A_W = LINE_MOMENT_X_W,
  parameter int Y_W = LINE_MOMENT_SUM_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ce,
  input  logic [A_W-1:0] A,
  output logic [Y_W-1:0] Y
);

  logic [Y_W-1:0] r_y;

  // NOTE: sequential state is always updated with non-blocking assignments so
  // every flop samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_y <= '0;
    end else if (ce) begin
      r_y <= r_y + Y_W'(A);
    end
  end

  assign Y = r_y;

endmodule

// File: rtl/line_moment_ctrl.sv
// -----------------------------------------------------------------------------
// line_moment_ctrl
//
// Per-line scheduler for the skin-segmentation accumulator. Counts pixel
// columns, gates the summator with the skin mask so it builds the sum of x of
// skin pixels, and at each line end latches {sum_x, count, line index} into a
// result register that is read out through a valid/ready handshake.
//
// Parameters:
//   H_MAX   pixels per line that are accumulated (1..724, keeps sum in 19 b)
//   LINE_W  width of the line index
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   vsync      in   one-cycle frame-start pulse
//   de         in   active-video strobe, one pixel per cycle
//   skin       in   skin mask for the current pixel (used only when de=1)
//   res_sum    out  sum of x of skin pixels in the reported line
//   res_cnt    out  number of skin pixels in the reported line
//   res_line   out  0-based line index within the frame
//   res_valid  out  result held and available
//   res_ready  in   consumer takes the result
//   overrun    out  sticky: a line result was dropped (cleared by rst only)
//
// Build option:
//   LINE_MOMENT_SKIP_EMPTY_EN  when defined, a line with no skin pixels loads
//                              no result and cannot set overrun; the line
//                              index still advances.
// -----------------------------------------------------------------------------
module line_moment_ctrl
  import line_moment_ctrl_pkg::*;
#(
  parameter int H_MAX  = 640,
  parameter int LINE_W = 9
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         vsync,
  input  logic                         de,
  input  logic                         skin,
  output logic [LINE_MOMENT_SUM_W-1:0] res_sum,
  output logic [LINE_MOMENT_CNT_W-1:0] res_cnt,
  output logic [LINE_W-1:0]            res_line,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic                         overrun
);

  localparam logic [LINE_MOMENT_X_W-1:0] H_MAX_X = LINE_MOMENT_X_W'(H_MAX);

  typedef struct packed {
    logic [LINE_MOMENT_SUM_W-1:0] sum;
    logic [LINE_MOMENT_CNT_W-1:0] cnt;
    logic [LINE_W-1:0]            line;
  } res_t;

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  line_state_e                  r_state;
  line_state_e                  w_state_nxt;

  logic                         r_de_d;
  logic [LINE_MOMENT_X_W-1:0]   r_x;
  logic [LINE_MOMENT_CNT_W-1:0] r_cnt;
  logic [LINE_W-1:0]            r_line_idx;
  res_t                         r_res;
  logic                         r_valid;
  logic                         r_overrun;

  logic [LINE_MOMENT_SUM_W-1:0] w_y;
  logic                         w_ce;
  logic                         w_de_rise;
  logic                         w_de_fall;
  logic                         w_acc_clr;
  logic                         w_in_accum;
  logic                         w_line_end;
  logic                         w_has_result;
  logic                         w_commit;
  logic                         w_load;

  // ---------------------------------------------------------------------------
  // Edge detection and accumulator gating
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_de_d <= 1'b0;
    end else begin
      r_de_d <= de;
    end
  end

  assign w_de_rise = de & ~r_de_d;
  assign w_de_fall = r_de_d & ~de;

  // Any de fall or vsync empties the accumulation path. A fall that is not a
  // committed line end (the tail of a line cut by vsync) is discarded here.
  assign w_acc_clr = w_de_fall | vsync;

  assign w_ce = de & skin & (r_x < H_MAX_X);

  // ---------------------------------------------------------------------------
  // Scheduler FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: every variable driven in a combinational block gets a default
  // assignment first so no path through the block leaves a latch behind.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_de_rise && !vsync) begin
          w_state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        if (vsync) begin
          w_state_nxt = IDLE;
        end else if (w_de_fall) begin
          w_state_nxt = COMMIT;
        end
      end
      COMMIT: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    w_in_accum = (r_state == ACCUM);
  end

  // Only a line that was started and not cut by vsync reaches a line end.
  assign w_line_end = w_in_accum & w_de_fall & ~vsync;

  // ---------------------------------------------------------------------------
  // Column counter, skin counter, summator
  // ---------------------------------------------------------------------------
  // Held at 0 during blanking so the first de cycle of every line sees x=0.
  always_ff @(posedge clk) begin
    if (rst || vsync || !de) begin
      r_x <= '0;
    end else begin
      r_x <= sat_inc(r_x, H_MAX_X);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_acc_clr) begin
      r_cnt <= '0;
    end else if (w_ce) begin
      r_cnt <= r_cnt + LINE_MOMENT_CNT_W'(1);
    end
  end

  summator #(
    .A_W (LINE_MOMENT_X_W),
    .Y_W (LINE_MOMENT_SUM_W)
  ) u_summator (
    .clk (clk),
    .rst (rst | w_acc_clr),
    .ce  (w_ce),
    .A   (r_x),
    .Y   (w_y)
  );

  // ---------------------------------------------------------------------------
  // Line index: advances on every line end, loaded or not
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || vsync) begin
      r_line_idx <= '0;
    end else if (w_line_end) begin
      r_line_idx <= r_line_idx + LINE_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Result register and handshake
  // ---------------------------------------------------------------------------
`ifdef LINE_MOMENT_SKIP_EMPTY_EN
  assign w_has_result = (r_cnt != '0);
`else
  assign w_has_result = 1'b1;
`endif

  assign w_commit = w_line_end & w_has_result;
  // A consumer taking the held result on the commit edge frees the slot.
  assign w_load   = w_commit & (~r_valid | res_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_res     <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_load) begin
        r_res.sum  <= w_y;
        r_res.cnt  <= r_cnt;
        r_res.line <= r_line_idx;
        r_valid    <= 1'b1;
      end else if (r_valid && res_ready) begin
        r_valid <= 1'b0;
      end

      if (w_commit && !w_load) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign res_sum   = r_res.sum;
  assign res_cnt   = r_res.cnt;
  assign res_line  = r_res.line;
  assign res_valid = r_valid;
  assign overrun   = r_overrun;

endmodule
